// File: rtl/liteic_axil_sram_slave_if.sv
// AXI-lite channel set (20-bit port address at default) between interconnect and SRAM endpoint.
// master: drives AR/AW/W payloads and valids, R/B readies.
// slave : drives AR/AW/W readies, R/B payloads and valids.
interface liteic_axil_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESP_WIDTH = 1
);
    localparam int unsigned PORT_AW    = ADDR_WIDTH - 12;
    localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic [PORT_AW-1:0]    ar_addr;
    logic [3:0]            ar_qos;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [RESP_WIDTH-1:0] r_resp;
    logic                  r_valid;
    logic                  r_ready;
    logic [PORT_AW-1:0]    aw_addr;
    logic [3:0]            aw_qos;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;
    logic [RESP_WIDTH-1:0] b_resp;
    logic                  b_valid;
    logic                  b_ready;

    modport master (
        output ar_addr, ar_qos, ar_valid, r_ready,
        output aw_addr, aw_qos, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_ready, r_data, r_resp, r_valid,
        input  aw_ready, w_ready, b_resp, b_valid
    );

    modport slave (
        input  ar_addr, ar_qos, ar_valid, r_ready,
        input  aw_addr, aw_qos, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_ready, r_data, r_resp, r_valid,
        output aw_ready, w_ready, b_resp, b_valid
    );
endinterface

// File: rtl/liteic_axil_sram_slave.sv
// AXI-lite slave endpoint turning single read/write transactions into
// single-port synchronous SRAM accesses, with QoS arbitration and
// alternating tie-break between simultaneous read and write requests.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   s                 AXI-lite channels (slave modport)
//   mem_en_o/we_o     SRAM enable and byte write enables (grant cycle only)
//   mem_addr_o        SRAM word address
//   mem_wdata_o       SRAM write data
//   mem_rdata_i       SRAM read data, one cycle after a read enable
module liteic_axil_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESP_WIDTH = 1,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    liteic_axil_sram_slave_if.slave         s,
    output logic                            mem_en_o,
    output logic [(DATA_WIDTH+7)/8-1:0]     mem_we_o,
    output logic [MEM_AW-1:0]               mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);
    localparam int unsigned PORT_AW    = ADDR_WIDTH - 12;
    localparam int unsigned STRB_WIDTH = (DATA_WIDTH + 7) / 8;
    localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_HI     = OFF_W + MEM_AW;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_RESP} state_t;
    typedef enum logic {GNT_READ, GNT_WRITE} grant_t;

    state_t                state_q, state_n;
    grant_t                last_grant_q, last_grant_n;
    logic                  rd_oor_q, rd_oor_n;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_n;
    logic [RESP_WIDTH-1:0] r_resp_q, r_resp_n;
    logic                  r_valid_q, r_valid_n;
    logic [RESP_WIDTH-1:0] b_resp_q, b_resp_n;
    logic                  b_valid_q, b_valid_n;
    logic                  ar_ready_c, wr_ready_c;

    // Address decode: word index plus range check on everything above it.
    logic [MEM_AW-1:0] ar_idx, aw_idx;
    logic              ar_in_range, aw_in_range;
    logic [PORT_AW-1:0] ar_hi, aw_hi;

    assign ar_idx      = s.ar_addr[OFF_W +: MEM_AW];
    assign aw_idx      = s.aw_addr[OFF_W +: MEM_AW];
    assign ar_hi       = s.ar_addr >> IDX_HI;
    assign aw_hi       = s.aw_addr >> IDX_HI;
    assign ar_in_range = (ar_hi == '0);
    assign aw_in_range = (aw_hi == '0);

    // Read wins on higher QoS, or on a tie when the last grant went to a write.
    logic rd_pend, wr_pend, rd_wins;
    assign rd_pend = s.ar_valid;
    assign wr_pend = s.aw_valid && s.w_valid;
    assign rd_wins = rd_pend && (!wr_pend || (s.ar_qos > s.aw_qos) ||
                                 ((s.ar_qos == s.aw_qos) && (last_grant_q == GNT_WRITE)));

    assign s.ar_ready = ar_ready_c;
    assign s.aw_ready = wr_ready_c;
    assign s.w_ready  = wr_ready_c;
    assign s.r_data   = r_data_q;
    assign s.r_resp   = r_resp_q;
    assign s.r_valid  = r_valid_q;
    assign s.b_resp   = b_resp_q;
    assign s.b_valid  = b_valid_q;

    // State and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_WRITE;
            rd_oor_q     <= 1'b0;
            r_data_q     <= '0;
            r_resp_q     <= '0;
            r_valid_q    <= 1'b0;
            b_resp_q     <= '0;
            b_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            last_grant_q <= last_grant_n;
            rd_oor_q     <= rd_oor_n;
            r_data_q     <= r_data_n;
            r_resp_q     <= r_resp_n;
            r_valid_q    <= r_valid_n;
            b_resp_q     <= b_resp_n;
            b_valid_q    <= b_valid_n;
        end
    end

    // Next-state, grant-cycle handshakes and SRAM strobes.
    always_comb begin
        state_n      = state_q;
        last_grant_n = last_grant_q;
        rd_oor_n     = rd_oor_q;
        r_data_n     = r_data_q;
        r_resp_n     = r_resp_q;
        r_valid_n    = r_valid_q;
        b_resp_n     = b_resp_q;
        b_valid_n    = b_valid_q;
        ar_ready_c   = 1'b0;
        wr_ready_c   = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = '0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (rd_wins) begin
                    ar_ready_c   = 1'b1;
                    mem_en_o     = ar_in_range;
                    mem_addr_o   = ar_idx;
                    rd_oor_n     = !ar_in_range;
                    last_grant_n = GNT_READ;
                    state_n      = RD_WAIT;
                end else if (wr_pend) begin
                    wr_ready_c = 1'b1;
                    if (aw_in_range) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = s.w_strb;
                        mem_addr_o  = aw_idx;
                        mem_wdata_o = s.w_data;
                    end
                    b_resp_n     = RESP_WIDTH'(!aw_in_range);
                    b_valid_n    = 1'b1;
                    last_grant_n = GNT_WRITE;
                    state_n      = WR_RESP;
                end
            end
            RD_WAIT: begin
                r_data_n  = rd_oor_q ? '0 : mem_rdata_i;
                r_resp_n  = RESP_WIDTH'(rd_oor_q);
                r_valid_n = 1'b1;
                state_n   = RD_RESP;
            end
            RD_RESP: begin
                if (s.r_ready) begin
                    r_valid_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            WR_RESP: begin
                if (s.b_ready) begin
                    b_valid_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // No handshake or SRAM access may escape while reset is held.
        if (rst_i) begin
            ar_ready_c = 1'b0;
            wr_ready_c = 1'b0;
            mem_en_o   = 1'b0;
            mem_we_o   = '0;
        end
    end
endmodule

// File: tb/tb_liteic_axil_sram_slave.sv
module tb_liteic_axil_sram_slave;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 1;
    localparam int unsigned MAW = 10;

    typedef struct {
        bit          is_wr;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          exp_en;
        logic [3:0]  exp_we;
        logic [9:0]  exp_maddr;
        logic [31:0] exp_rdata;
        bit          exp_resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] sram [1024];
    int          en_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          en0;
    int          wait_n;
    logic [3:0]  cap_we;
    logic [9:0]  cap_addr;
    logic [31:0] cap_wdata;
    vec_t        vecs [12];

    liteic_axil_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus();

    liteic_axil_sram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .MEM_AW(MAW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .s           (bus),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM plus a count of every enabled cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= sram[mem_addr];
            en_cnt    <= en_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with valids set; returns at the negedge of the grant cycle.
    task automatic wait_ready(input bit rd, input string name);
        logic rdy;
        wait_n = 0;
        @(negedge clk);
        rdy = rd ? bus.ar_ready : bus.aw_ready;
        while (!rdy && wait_n < 16) begin
            @(negedge clk);
            rdy = rd ? bus.ar_ready : bus.aw_ready;
            wait_n++;
        end
        chk({name, "_ready"}, 32'(rdy), 32'd1);
        if (!rd) chk({name, "_w_ready"}, 32'(bus.w_ready), 32'd1);
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        en0       = en_cnt;
    endtask

    task automatic issue_read(input logic [19:0] addr, input string name);
        bus.ar_addr  = addr;
        bus.ar_qos   = 4'd0;
        bus.ar_valid = 1'b1;
        wait_ready(1'b1, name);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [19:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input string name);
        bus.aw_addr  = addr;
        bus.aw_qos   = 4'd0;
        bus.w_data   = data;
        bus.w_strb   = strb;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        wait_ready(1'b0, name);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
    endtask

    // Starts at posedge+1 after the AR handshake; ends at posedge+1 after the R handshake.
    task automatic complete_read(input logic [31:0] exp_data, input bit exp_resp,
                                 input bit exp_en, input int hold, input string name);
        @(negedge clk);
        chk({name, "_rvalid_t1"}, 32'(bus.r_valid), 32'd0);
        @(negedge clk);
        chk({name, "_rvalid_t2"}, 32'(bus.r_valid), 32'd1);
        chk({name, "_rdata"}, bus.r_data, exp_data);
        chk({name, "_rresp"}, 32'(bus.r_resp), 32'(exp_resp));
        if (hold > 0) begin
            bus.ar_valid = 1'b1;
            bus.aw_valid = 1'b1;
            bus.w_valid  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({name, "_hold_rvalid"}, 32'(bus.r_valid), 32'd1);
                chk({name, "_hold_rdata"}, bus.r_data, exp_data);
                chk({name, "_hold_rresp"}, 32'(bus.r_resp), 32'(exp_resp));
                chk({name, "_hold_ar_ready"}, 32'(bus.ar_ready), 32'd0);
                chk({name, "_hold_aw_ready"}, 32'(bus.aw_ready), 32'd0);
            end
            bus.ar_valid = 1'b0;
            bus.aw_valid = 1'b0;
            bus.w_valid  = 1'b0;
        end
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        chk({name, "_rvalid_done"}, 32'(bus.r_valid), 32'd0);
        chk({name, "_mem_en_cycles"}, 32'(en_cnt - en0), 32'(exp_en));
    endtask

    // Starts at posedge+1 after the AW/W handshake; ends at posedge+1 after the B handshake.
    task automatic complete_write(input bit exp_resp, input bit exp_en, input string name);
        @(negedge clk);
        chk({name, "_bvalid_t1"}, 32'(bus.b_valid), 32'd1);
        chk({name, "_bresp"}, 32'(bus.b_resp), 32'(exp_resp));
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        chk({name, "_bvalid_done"}, 32'(bus.b_valid), 32'd0);
        chk({name, "_mem_en_cycles"}, 32'(en_cnt - en0), 32'(exp_en));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        string nm;
        vec_t  v;
        int    rd_left;
        int    wr_left;
        bit    got_rd;

        vecs[0]  = '{1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 1'b1, 4'hF, 10'd4,     32'h0,        1'b0};
        vecs[1]  = '{1'b0, 20'h00010, 32'h0,        4'h0, 1'b1, 4'h0, 10'd4,     32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 20'h00000, 32'hFFFFFFFF, 4'hF, 1'b1, 4'hF, 10'd0,     32'h0,        1'b0};
        vecs[3]  = '{1'b1, 20'h00000, 32'h11223344, 4'h3, 1'b1, 4'h3, 10'd0,     32'h0,        1'b0};
        vecs[4]  = '{1'b0, 20'h00000, 32'h0,        4'h0, 1'b1, 4'h0, 10'd0,     32'hFFFF3344, 1'b0};
        vecs[5]  = '{1'b0, 20'h01000, 32'h0,        4'h0, 1'b0, 4'h0, 10'd0,     32'h0,        1'b1};
        vecs[6]  = '{1'b1, 20'h01000, 32'h55555555, 4'hF, 1'b0, 4'h0, 10'd0,     32'h0,        1'b1};
        vecs[7]  = '{1'b1, 20'h00013, 32'hAAAAAAAA, 4'h0, 1'b1, 4'h0, 10'd4,     32'h0,        1'b0};
        vecs[8]  = '{1'b0, 20'h00012, 32'h0,        4'h0, 1'b1, 4'h0, 10'd4,     32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 20'hFFFFC, 32'h0,        4'h0, 1'b0, 4'h0, 10'd0,     32'h0,        1'b1};
        vecs[10] = '{1'b1, 20'h00FFC, 32'h5A5A5A5A, 4'hF, 1'b1, 4'hF, 10'h3FF,   32'h0,        1'b0};
        vecs[11] = '{1'b0, 20'h00FFF, 32'h0,        4'h0, 1'b1, 4'h0, 10'h3FF,   32'h5A5A5A5A, 1'b0};

        for (int i = 0; i < 1024; i++) sram[i] = '0;

        // Reset with every request valid: nothing may be accepted.
        rst          = 1'b1;
        bus.ar_addr  = 20'h00000;
        bus.ar_qos   = 4'd0;
        bus.ar_valid = 1'b1;
        bus.aw_addr  = 20'h00000;
        bus.aw_qos   = 4'd0;
        bus.w_data   = 32'h0BADF00D;
        bus.w_strb   = 4'hF;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        bus.r_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ar_ready", 32'(bus.ar_ready), 32'd0);
        chk("reset_aw_ready", 32'(bus.aw_ready), 32'd0);
        chk("reset_mem_en",   32'(mem_en),       32'd0);
        chk("reset_r_valid",  32'(bus.r_valid),  32'd0);
        chk("reset_b_valid",  32'(bus.b_valid),  32'd0);
        chk("reset_r_data",   bus.r_data,        32'd0);
        chk("reset_r_resp",   32'(bus.r_resp),   32'd0);
        chk("reset_b_resp",   32'(bus.b_resp),   32'd0);
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mem_en_cycles", 32'(en_cnt), 32'd0);

        // Single transactions from the vector table.
        for (int i = 0; i < 12; i++) begin
            v  = vecs[i];
            nm = $sformatf("vec%0d", i);
            if (v.is_wr) issue_write(v.addr, v.data, v.strb, nm);
            else         issue_read(v.addr, nm);
            chk({nm, "_accept_wait"}, 32'(wait_n), 32'd0);
            chk({nm, "_mem_we"}, 32'(cap_we), 32'(v.exp_we));
            if (v.exp_en) chk({nm, "_mem_addr"}, 32'(cap_addr), 32'(v.exp_maddr));
            if (v.exp_en && v.is_wr) chk({nm, "_mem_wdata"}, cap_wdata, v.data);
            if (v.is_wr) complete_write(v.exp_resp, v.exp_en, nm);
            else         complete_read(v.exp_rdata, v.exp_resp, v.exp_en, 0, nm);
        end

        // Higher write QoS wins; the read waits until after the B handshake.
        bus.ar_addr  = 20'h00010;
        bus.ar_qos   = 4'd2;
        bus.ar_valid = 1'b1;
        bus.aw_addr  = 20'h00040;
        bus.aw_qos   = 4'd5;
        bus.w_data   = 32'hCAFEF00D;
        bus.w_strb   = 4'hF;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        @(negedge clk);
        chk("qos_aw_ready", 32'(bus.aw_ready), 32'd1);
        chk("qos_ar_ready", 32'(bus.ar_ready), 32'd0);
        en0 = en_cnt;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        @(negedge clk);
        chk("qos_ar_blocked", 32'(bus.ar_ready), 32'd0);
        chk("qos_bvalid",     32'(bus.b_valid),  32'd1);
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        @(negedge clk);
        chk("qos_ar_after_b", 32'(bus.ar_ready), 32'd1);
        en0 = en_cnt;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        complete_read(32'hDEADBEEF, 1'b0, 1'b1, 0, "qos_rd");
        issue_read(20'h00040, "qos_chk");
        complete_read(32'hCAFEF00D, 1'b0, 1'b1, 0, "qos_chk");

        // Stalled R channel: response held, no new request accepted.
        issue_read(20'h00000, "hold");
        complete_read(32'hFFFF3344, 1'b0, 1'b1, 5, "hold");
        issue_read(20'h00010, "post_hold");
        chk("post_hold_accept_wait", 32'(wait_n), 32'd0);
        complete_read(32'hDEADBEEF, 1'b0, 1'b1, 0, "post_hold");

        // Equal QoS from reset: grants alternate starting with a read.
        pulse_reset();
        rd_left      = 4;
        wr_left      = 4;
        bus.ar_addr  = 20'h00010;
        bus.ar_qos   = 4'd7;
        bus.aw_addr  = 20'h00100;
        bus.aw_qos   = 4'd7;
        bus.w_strb   = 4'hF;
        for (int k = 0; k < 8; k++) begin
            bus.ar_valid = (rd_left > 0);
            bus.aw_valid = (wr_left > 0);
            bus.w_valid  = (wr_left > 0);
            bus.w_data   = 32'(k);
            wait_n = 0;
            @(negedge clk);
            while (!bus.ar_ready && !bus.aw_ready && wait_n < 16) begin
                @(negedge clk);
                wait_n++;
            end
            nm = $sformatf("tie%0d", k);
            chk({nm, "_is_read"}, 32'(bus.ar_ready), 32'((k % 2) == 0));
            got_rd = bus.ar_ready;
            en0    = en_cnt;
            @(posedge clk); #1;
            if (got_rd) begin
                bus.ar_valid = 1'b0;
                rd_left--;
                complete_read(32'hDEADBEEF, 1'b0, 1'b1, 0, nm);
            end else begin
                bus.aw_valid = 1'b0;
                bus.w_valid  = 1'b0;
                wr_left--;
                complete_write(1'b0, 1'b1, nm);
            end
        end
        bus.ar_qos = 4'd0;
        bus.aw_qos = 4'd0;
        issue_read(20'h00100, "tie_chk");
        complete_read(32'd7, 1'b0, 1'b1, 0, "tie_chk");

        // Reset while a read response is pending.
        issue_read(20'h00000, "rst_rd");
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_pending", 32'(bus.r_valid), 32'd1);
        rst          = 1'b1;
        bus.aw_addr  = 20'h00000;
        bus.w_data   = 32'hBAD0BAD0;
        bus.w_strb   = 4'hF;
        bus.aw_valid = 1'b1;
        bus.w_valid  = 1'b1;
        en0          = en_cnt;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("rst_rd_rvalid", 32'(bus.r_valid), 32'd0);
        chk("rst_rd_bvalid", 32'(bus.b_valid), 32'd0);
        chk("rst_rd_rdata",  bus.r_data,       32'd0);
        chk("rst_rd_mem_en_cycles", 32'(en_cnt - en0), 32'd0);
        issue_read(20'h00000, "rst_rd_after");
        chk("rst_rd_after_accept_wait", 32'(wait_n), 32'd0);
        complete_read(32'hFFFF3344, 1'b0, 1'b1, 0, "rst_rd_after");

        // Reset while a write response is pending.
        issue_write(20'h00020, 32'h12345678, 4'hF, "rst_wr");
        @(negedge clk);
        chk("rst_wr_pending", 32'(bus.b_valid), 32'd1);
        rst = 1'b1;
        en0 = en_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wr_bvalid", 32'(bus.b_valid), 32'd0);
        chk("rst_wr_rvalid", 32'(bus.r_valid), 32'd0);
        chk("rst_wr_bresp",  32'(bus.b_resp),  32'd0);
        chk("rst_wr_mem_en_cycles", 32'(en_cnt - en0), 32'd0);
        issue_read(20'h00020, "rst_wr_after");
        chk("rst_wr_after_accept_wait", 32'(wait_n), 32'd0);
        complete_read(32'h12345678, 1'b0, 1'b1, 0, "rst_wr_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
